// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   fifo_aw()   : address width needed to index `depth` entries (ceil(log2)).
//   FIFO_*      : default configuration (8-bit words, 32 entries).
//   fifo_ptr_t  : pointer type for the default configuration; one bit wider
//                 than the address so full and empty can be told apart.
package fifo_pkg;

    function automatic int fifo_aw(input int depth);
        int aw;
        aw = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                aw = i + 1;
            end
        end
        return aw;
    endfunction

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_AW    = fifo_aw(FIFO_DEPTH);

    typedef logic [FIFO_AW:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DEPTH x WIDTH, single clock.
//   i_clk      : clock, all activity on the rising edge
//   i_rst      : synchronous active-high reset; clears only the read register
//   i_wr_en    : write strobe (already qualified by the caller)
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe (already qualified by the caller)
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, holds its value when i_rd_en is low
// The storage array is deliberately not reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO with registered read data, full/empty flags and exposed
// binary pointers.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (priority over wr_en/rd_en)
//   wr_data  : write data, captured when a write is accepted
//   wr_en    : write request
//   full     : FIFO holds DEPTH entries
//   rd_data  : registered read data, valid the cycle after an accepted read
//   rd_en    : read request
//   empty    : FIFO holds no entries
//   ptr_w    : write pointer, MSB is the wrap bit
//   ptr_r    : read pointer, MSB is the wrap bit
//
// Handshake: a write transfers on a rising edge where wr_en=1 and full=0; a
// read transfers on a rising edge where rd_en=1 and empty=0. Requests made
// while the matching flag is set are dropped, not held.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo_top
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW   = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en,
    output logic             empty,
    output logic [AW:0]      ptr_w,
    output logic [AW:0]      ptr_r
);

    logic [AW:0] r_ptr_w;
    logic [AW:0] r_ptr_r;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_empty;
    logic        w_full;

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign w_empty = (r_ptr_w == r_ptr_r);
    assign w_full  = (r_ptr_w[AW] != r_ptr_r[AW]) &&
                     (r_ptr_w[AW-1:0] == r_ptr_r[AW-1:0]);

    // Gating the RAM write with rst keeps a reset cycle from touching storage.
    assign w_wr_acc = wr_en & ~w_full & ~rst;
    assign w_rd_acc = rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_w <= '0;
            r_ptr_r <= '0;
        end else begin
            if (w_wr_acc) begin
                r_ptr_w <= r_ptr_w + (AW+1)'(1);
            end
            if (w_rd_acc) begin
                r_ptr_r <= r_ptr_r + (AW+1)'(1);
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_ptr_w[AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_ptr_r[AW-1:0]),
        .o_rd_data (rd_data)
    );

    assign full  = w_full;
    assign empty = w_empty;
    assign ptr_w = r_ptr_w;
    assign ptr_r = r_ptr_r;

endmodule

// File: tb/tb_sync_fifo_top.sv
module tb_sync_fifo_top;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    // ---------------- clock / DUT ----------------
    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             empty;
    logic [AW:0]      ptr_w;
    logic [AW:0]      ptr_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_top #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .rd_data (rd_data),
        .rd_en   (rd_en),
        .empty   (empty),
        .ptr_w   (ptr_w),
        .ptr_r   (ptr_r)
    );

    // ---------------- reference model ----------------
    // Occupancy-based queue model: pointers are just counts of accepted
    // transfers modulo 64, flags come from the queue size.
    logic [WIDTH-1:0] exp_q[$];
    logic [AW:0]      m_pw;
    logic [AW:0]      m_pr;
    logic [WIDTH-1:0] m_rd;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one clock cycle, advance the model, settle past the edge.
    task automatic cycle(input logic r, input logic w, input logic rdx, input logic [WIDTH-1:0] d);
        bit wa;
        bit ra;
        rst     = r;
        wr_en   = w;
        rd_en   = rdx;
        wr_data = d;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_pw = '0;
            m_pr = '0;
            m_rd = '0;
        end else begin
            wa = w && (exp_q.size() < DEPTH);
            ra = rdx && (exp_q.size() > 0);
            if (ra) begin
                m_rd = exp_q.pop_front();
                m_pr = m_pr + 1'b1;
            end
            if (wa) begin
                exp_q.push_back(d);
                m_pw = m_pw + 1'b1;
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_empty"},   32'(empty),   32'(exp_q.size() == 0));
        check({tag, "_full"},    32'(full),    32'(exp_q.size() == DEPTH));
        check({tag, "_ptr_w"},   32'(ptr_w),   32'(m_pw));
        check({tag, "_ptr_r"},   32'(ptr_r),   32'(m_pr));
        check({tag, "_rd_data"}, 32'(rd_data), 32'(m_rd));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rst;
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] data;
        logic             e;
        logic             f;
        logic [AW:0]      pw;
        logic [AW:0]      pr;
        logic [WIDTH-1:0] rdd;
    } vec_t;

    vec_t vecs[11];

    logic [AW:0] occ;
    int          wbias;
    int          rbias;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        m_pw     = '0;
        m_pr     = '0;
        m_rd     = '0;

        //            rst   wr    rd    data   e     f     pw    pr    rd_data
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 6'd0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 6'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 6'd1, 6'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 6'd2, 6'd0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'd2, 6'd1, 8'hA5};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 6'd3, 6'd2, 8'h3C};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd3, 6'd3, 8'h7E};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd3, 6'd3, 8'h7E};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 6'd4, 6'd3, 8'h7E};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd4, 6'd4, 8'h11};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd4, 6'd4, 8'h11};

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data);
            check("tbl_empty",   32'(empty),   32'(vecs[i].e));
            check("tbl_full",    32'(full),    32'(vecs[i].f));
            check("tbl_ptr_w",   32'(ptr_w),   32'(vecs[i].pw));
            check("tbl_ptr_r",   32'(ptr_r),   32'(vecs[i].pr));
            check("tbl_rd_data", 32'(rd_data), 32'(vecs[i].rdd));
        end

        // 1. reset for two cycles
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("rst_empty", 32'(empty),   32'd1);
        check("rst_full",  32'(full),    32'd0);
        check("rst_ptr_w", 32'(ptr_w),   32'd0);
        check("rst_ptr_r", 32'(ptr_r),   32'd0);
        check("rst_rd",    32'(rd_data), 32'd0);

        // 2. 33 writes, the last one dropped
        for (int i = 0; i < 33; i++) begin
            cycle(1'b0, 1'b1, 1'b0, WIDTH'(i));
            check_all("fill");
            if (i >= 31) begin
                check("fill_full",  32'(full),  32'd1);
                check("fill_ptr_w", 32'(ptr_w), 32'd32);
            end
        end

        // 3. 33 reads, the last one ignored
        for (int i = 0; i < 33; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            check_all("drain");
            if (i < 32) begin
                check("drain_data", 32'(rd_data), 32'(i));
            end else begin
                check("drain_hold",  32'(rd_data), 32'h1F);
                check("drain_empty", 32'(empty),   32'd1);
                check("drain_ptr_r", 32'(ptr_r),   32'd32);
            end
        end

        // 4. simultaneous read/write starting from empty
        for (int i = 0; i < 33; i++) begin
            cycle(1'b0, 1'b1, 1'b1, WIDTH'(8'h40 + i));
            check_all("rw");
            occ = ptr_w - ptr_r;
            check("rw_occ",  32'(occ),  32'd1);
            check("rw_full", 32'(full), 32'd0);
            if (i == 0) begin
                check("rw_first_hold", 32'(rd_data), 32'h1F);
            end else begin
                check("rw_data", 32'(rd_data), 32'(8'h40 + i - 1));
            end
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
        check_all("rw_tail");
        check("rw_tail_data", 32'(rd_data), 32'h60);

        // 5. fill/drain laps so the pointers wrap past 63
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < DEPTH; i++) begin
                cycle(1'b0, 1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
                check_all("lap_fill");
            end
            check("lap_full", 32'(full), 32'd1);
            for (int i = 0; i < DEPTH; i++) begin
                cycle(1'b0, 1'b0, 1'b1, '0);
                check_all("lap_drain");
            end
            check("lap_empty", 32'(empty), 32'd1);
        end

        // 6. reset mid-operation discards queued data
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, WIDTH'(8'h90 + i));
        end
        check_all("pre_rst");
        cycle(1'b1, 1'b1, 1'b1, 8'hEE);
        check("mid_rst_ptr_w", 32'(ptr_w), 32'd0);
        check("mid_rst_ptr_r", 32'(ptr_r), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full",  32'(full),  32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'hC1);
        cycle(1'b0, 1'b1, 1'b0, 8'hC2);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("post_rst_rd0", 32'(rd_data), 32'hC1);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("post_rst_rd1", 32'(rd_data), 32'hC2);
        check_all("post_rst");

        // Random traffic with phase-varying bias to reach both full and empty.
        wbias = 50;
        rbias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                wbias = $urandom_range(10, 90);
                rbias = $urandom_range(10, 90);
            end
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < wbias),
                  ($urandom_range(0, 99) < rbias),
                  WIDTH'($urandom_range(0, 255)));
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
